ham_stream_decoder: RTL and testbench

Parametrised, pipelined Hamming(7,4) decoder for the receive path after FSK demodulation, ahead of PCM expansion. It decodes NUM_LANES codewords per beat into 4-bit nibbles with single-error correction, or SEC-DED when enabled. Data moves over valid/ready handshakes with full backpressure. Saturating counters record corrected and uncorrectable lane events.

---
 rtl/ham_pkg.sv | 33 +++
 rtl/ham_lane_dec.sv | 29 ++
 rtl/ham_stream_decoder.sv | 122 ++++++++++++
 tb/tb_ham_stream_decoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared constants and helpers for the streaming Hamming(7,4) decoder.
package ham_pkg;

    localparam logic [2:0] SYN_D3 = 3'b111;
    localparam logic [2:0] SYN_D2 = 3'b110;
    localparam logic [2:0] SYN_D1 = 3'b101;
    localparam logic [2:0] SYN_D0 = 3'b011;

    localparam int unsigned ACC_W  = 32;
    localparam int unsigned ACC_W1 = ACC_W + 1;
    localparam int unsigned POP_W  = 6;

    function automatic logic [POP_W-1:0] popcount(input logic [ACC_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < ACC_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // Adds inc to a and clamps at the all-ones value of a w-bit counter.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] inc,
                                                 input int unsigned      w);
        logic [ACC_W:0] sum;
        logic [ACC_W:0] lim;
        sum = {1'b0, a} + {1'b0, inc};
        lim = (ACC_W1'(1) << w) - ACC_W1'(1);
        return (sum > lim) ? lim[ACC_W-1:0] : sum[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/ham_lane_dec.sv
// Combinational single-lane corrector: applies the syndrome to the data nibble.
module ham_lane_dec
    import ham_pkg::*;
(
    input  logic [3:0] data,
    input  logic [2:0] syn,
    input  logic       q,
    output logic [3:0] nibble_c,
    output logic       corr_c,
    output logic       uncorr_c
);

    // q=1 marks a correctable (odd-weight) error; nonzero syndrome with q=0 is a double error.
    always_comb begin
        nibble_c = data;
        corr_c   = q;
        uncorr_c = (syn != 3'b000) && !q;
        if (q) begin
            case (syn)
                SYN_D3:  nibble_c[3] = ~data[3];
                SYN_D2:  nibble_c[2] = ~data[2];
                SYN_D1:  nibble_c[1] = ~data[1];
                SYN_D0:  nibble_c[0] = ~data[0];
                default: nibble_c = data;
            endcase
        end
    end

endmodule

// File: rtl/ham_stream_decoder.sv
// Two-stage valid/ready Hamming(7,4) stream decoder with optional SEC-DED and
// saturating corrected/uncorrectable lane counters.
module ham_stream_decoder
    import ham_pkg::*;
#(
    parameter  int unsigned NUM_LANES = 2,
    parameter  int unsigned SECDED    = 0,
    parameter  int unsigned CNT_W     = 16,
    localparam int unsigned CW        = 7 + SECDED,
    localparam int unsigned IN_W      = NUM_LANES * CW,
    localparam int unsigned OUT_W     = 4 * NUM_LANES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [NUM_LANES-1:0] out_corr,
    output logic [NUM_LANES-1:0] out_uncorr,
    input  logic                 stat_clr,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     uncorr_cnt
);

    logic                        v1;
    logic [NUM_LANES-1:0][3:0]   data1;
    logic [NUM_LANES-1:0][2:0]   syn1;
    logic [NUM_LANES-1:0]        q1;

    logic [NUM_LANES-1:0][3:0]   data_c;
    logic [NUM_LANES-1:0][2:0]   syn_c;
    logic [NUM_LANES-1:0]        q_c;
    logic [NUM_LANES-1:0][3:0]   nib_c;
    logic [NUM_LANES-1:0]        corr_c;
    logic [NUM_LANES-1:0]        uncorr_c;

    logic                        adv2_c;
    logic                        out_hs_c;

    assign adv2_c   = !out_valid || out_ready;
    assign in_ready = !v1 || adv2_c;
    assign out_hs_c = out_valid && out_ready;

    // Without SEC-DED any nonzero syndrome is treated as a single error, so q = |syn.
    always_comb begin
        data_c = '0;
        syn_c  = '0;
        q_c    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin : g_syn
            logic [6:0] c;
            c         = in_code[k*CW +: 7];
            data_c[k] = c[6:3];
            syn_c[k]  = {c[6] ^ c[5] ^ c[4] ^ c[2],
                         c[6] ^ c[5] ^ c[3] ^ c[1],
                         c[6] ^ c[4] ^ c[3] ^ c[0]};
            q_c[k]    = (SECDED != 0) ? ^in_code[k*CW +: CW] : |syn_c[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            data1 <= '0;
            syn1  <= '0;
            q1    <= '0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                data1 <= data_c;
                syn1  <= syn_c;
                q1    <= q_c;
            end
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        ham_lane_dec u_dec (
            .data     (data1[k]),
            .syn      (syn1[k]),
            .q        (q1[k]),
            .nibble_c (nib_c[k]),
            .corr_c   (corr_c[k]),
            .uncorr_c (uncorr_c[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_corr   <= '0;
            out_uncorr <= '0;
        end else if (adv2_c) begin
            out_valid <= v1;
            if (v1) begin
                out_data   <= nib_c;
                out_corr   <= corr_c;
                out_uncorr <= uncorr_c;
            end
        end
    end

    // Counters advance only on an output handshake; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (stat_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_hs_c) begin
            corr_cnt   <= CNT_W'(sat_add(ACC_W'(corr_cnt),
                                         ACC_W'(popcount(ACC_W'(out_corr))), CNT_W));
            uncorr_cnt <= CNT_W'(sat_add(ACC_W'(uncorr_cnt),
                                         ACC_W'(popcount(ACC_W'(out_uncorr))), CNT_W));
        end
    end

endmodule

// File: tb/tb_ham_stream_decoder.sv
// Self-checking bench: a plain-SECDED-off decoder (4-bit counters) and a SEC-DED
// decoder, checked against a nearest-codeword reference model.
module tb_ham_stream_decoder;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] corr;
        logic [1:0] uncorr;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        a_valid, a_ready, a_clr;
    logic [15:0] a_code;

    logic        ir0, ov0, ir1, ov1;
    logic [7:0]  od0, od1;
    logic [1:0]  oc0, ou0, oc1, ou1;
    logic [3:0]  cc0, uc0;
    logic [15:0] cc1, uc1;

    logic        m_ir, m_ov;
    logic [7:0]  m_od;
    logic [1:0]  m_oc, m_ou;
    logic [15:0] m_cc, m_uc;

    int          checks = 0;
    int          failures = 0;
    beat_t       exp_q[$];
    logic [15:0] stim_q[$];
    int          occ;
    int unsigned m_corr[2];
    int unsigned m_uncorr[2];
    int unsigned cmax[2];

    always #5 clk = ~clk;

    ham_stream_decoder #(.NUM_LANES(2), .SECDED(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_valid & ~sel), .in_ready(ir0), .in_code(a_code[13:0]),
        .out_valid(ov0), .out_ready(a_ready | sel), .out_data(od0),
        .out_corr(oc0), .out_uncorr(ou0), .stat_clr(a_clr & ~sel),
        .corr_cnt(cc0), .uncorr_cnt(uc0)
    );

    ham_stream_decoder #(.NUM_LANES(2), .SECDED(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_valid & sel), .in_ready(ir1), .in_code(a_code),
        .out_valid(ov1), .out_ready(a_ready | ~sel), .out_data(od1),
        .out_corr(oc1), .out_uncorr(ou1), .stat_clr(a_clr & sel),
        .corr_cnt(cc1), .uncorr_cnt(uc1)
    );

    assign m_ir = sel ? ir1 : ir0;
    assign m_ov = sel ? ov1 : ov0;
    assign m_od = sel ? od1 : od0;
    assign m_oc = sel ? oc1 : oc0;
    assign m_ou = sel ? ou1 : ou0;
    assign m_cc = sel ? cc1 : {12'd0, cc0};
    assign m_uc = sel ? uc1 : {12'd0, uc0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc7(input logic [3:0] d);
        return {d, d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
    endfunction

    function automatic logic [7:0] codeword(input bit s, input logic [3:0] d);
        return s ? {^enc7(d), enc7(d)} : {1'b0, enc7(d)};
    endfunction

    // Reference: decode each lane to the nearest valid codeword by Hamming distance.
    function automatic beat_t model(input bit s, input logic [15:0] code);
        beat_t       b;
        logic [15:0] sh;
        logic [7:0]  c;
        int          best, d;
        logic [3:0]  bd;
        b  = '0;
        bd = '0;
        for (int k = 0; k < 2; k++) begin
            sh   = s ? (code >> (8 * k)) : (code >> (7 * k));
            c    = s ? sh[7:0] : {1'b0, sh[6:0]};
            best = 99;
            for (int n = 0; n < 16; n++) begin
                d = $countones(codeword(s, 4'(n)) ^ c);
                if (d < best) begin
                    best = d;
                    bd   = 4'(n);
                end
            end
            b.data[4*k +: 4] = (best <= 1) ? bd : c[6:3];
            b.corr[k]        = (best == 1);
            b.uncorr[k]      = (best >= 2);
        end
        return b;
    endfunction

    function automatic logic [15:0] gen_code(input bit s);
        logic [15:0] r;
        logic [7:0]  cw;
        int          w, ne, p1, p2;
        r = '0;
        w = s ? 8 : 7;
        for (int k = 0; k < 2; k++) begin
            cw = codeword(s, 4'($urandom_range(0, 15)));
            ne = $urandom_range(0, s ? 2 : 1);
            p1 = $urandom_range(0, w - 1);
            p2 = (p1 + 1 + $urandom_range(0, w - 2)) % w;
            if (ne >= 1) cw[p1] = ~cw[p1];
            if (ne == 2) cw[p2] = ~cw[p2];
            r = r | (16'(cw) << (k * w));
        end
        return r;
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned m);
        return (v > m) ? m : v;
    endfunction

    task automatic count_out(input beat_t b);
        m_corr[sel]   = sat(m_corr[sel] + $countones(b.corr), cmax[sel]);
        m_uncorr[sel] = sat(m_uncorr[sel] + $countones(b.uncorr), cmax[sel]);
    endtask

    task automatic chk_beat(input string tag, input beat_t e);
        chk($sformatf("%s data", tag), m_od, e.data);
        chk($sformatf("%s corr", tag), m_oc, e.corr);
        chk($sformatf("%s uncorr", tag), m_ou, e.uncorr);
    endtask

    task automatic chk_cnt(input string tag);
        chk($sformatf("%s corr_cnt", tag), m_cc, m_corr[sel]);
        chk($sformatf("%s uncorr_cnt", tag), m_uc, m_uncorr[sel]);
    endtask

    // One beat into an empty pipeline: checks 2-cycle latency, then hands it off.
    task automatic latency_beat(input logic [15:0] code, input bit clr, input string tag);
        beat_t e;
        @(negedge clk);
        e       = model(sel, code);
        a_ready = 1'b1;
        a_valid = 1'b1;
        a_code  = code;
        #1 chk($sformatf("%s in_ready", tag), m_ir, 1);
        @(negedge clk);
        a_valid = 1'b0;
        chk($sformatf("%s early out_valid", tag), m_ov, 0);
        @(negedge clk);
        chk($sformatf("%s out_valid", tag), m_ov, 1);
        chk_beat(tag, e);
        a_clr = clr;
        @(negedge clk);
        a_clr = 1'b0;
        if (clr) begin
            m_corr[sel]   = 0;
            m_uncorr[sel] = 0;
        end else begin
            count_out(e);
        end
        chk_cnt(tag);
    endtask

    // Streams stim_q through the selected DUT with optional stall and random handshakes.
    task automatic run_stream(input int stall, input bit rnd, input string tag);
        int   cyc;
        logic vin, ordy;
        cyc = 0;
        @(negedge clk);
        while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < 4000) begin
            vin     = (stim_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            ordy    = (cyc >= stall) && (!rnd || $urandom_range(0, 3) != 0);
            a_valid = vin;
            a_code  = vin ? stim_q[0] : 16'($urandom);
            a_ready = ordy;
            #1;
            chk($sformatf("%s in_ready", tag), m_ir, (occ < 2) || ordy);
            if (m_ov && exp_q.size() == 0) begin
                chk($sformatf("%s spurious out_valid", tag), m_ov, 0);
            end else if (m_ov) begin
                chk_beat(tag, exp_q[0]);
                if (ordy) begin
                    count_out(exp_q.pop_front());
                    occ--;
                end
            end
            if (vin && m_ir) begin
                exp_q.push_back(model(sel, stim_q.pop_front()));
                occ++;
            end
            @(negedge clk);
            cyc++;
        end
        a_valid = 1'b0;
        a_ready = 1'b1;
        chk($sformatf("%s drained", tag), 32'(exp_q.size() + stim_q.size()), 0);
        chk_cnt(tag);
    endtask

    task automatic chk_reset_state(input string tag);
        chk($sformatf("%s in_ready", tag), m_ir, 1);
        chk($sformatf("%s out_valid", tag), m_ov, 0);
        chk($sformatf("%s out_data", tag), m_od, 0);
        chk($sformatf("%s out_corr", tag), m_oc, 0);
        chk($sformatf("%s out_uncorr", tag), m_ou, 0);
        chk($sformatf("%s corr_cnt", tag), m_cc, 0);
        chk($sformatf("%s uncorr_cnt", tag), m_uc, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        sel     = 1'b0;
        a_valid = 1'b0;
        a_ready = 1'b1;
        a_clr   = 1'b0;
        a_code  = '0;
        occ     = 0;
        m_corr   = '{0, 0};
        m_uncorr = '{0, 0};
        cmax     = '{15, 65535};

        #12 chk_reset_state("rst0");
        sel = 1'b1;
        #1 chk_reset_state("rst1");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        latency_beat(16'h2CD9, 1'b0, "clean");

        for (int lane = 0; lane < 2; lane++)
            for (int b = 0; b < 7; b++)
                stim_q.push_back(16'h2CD9 ^ (16'd1 << (lane * 7 + b)));
        run_stream(0, 1'b0, "single");
        chk("single total", m_cc, 14);

        for (int i = 0; i < 6; i++) stim_q.push_back(16'h2CD9 ^ (16'd1 << i));
        run_stream(0, 1'b0, "sat");
        chk("sat hold", m_cc, 15);

        for (int i = 0; i < 4; i++) stim_q.push_back(gen_code(1'b0));
        run_stream(6, 1'b0, "bp");

        for (int i = 0; i < 200; i++) stim_q.push_back(gen_code(1'b0));
        run_stream(0, 1'b1, "rand0");

        sel = 1'b1;
        latency_beat(16'h595A, 1'b0, "dbl");
        chk("dbl uncorr total", m_uc, 1);
        for (int i = 0; i < 200; i++) stim_q.push_back(gen_code(1'b1));
        run_stream(0, 1'b1, "rand1");

        // Fill both stages, then reset asynchronously mid-stream.
        sel = 1'b0;
        @(negedge clk);
        a_ready = 1'b0;
        a_valid = 1'b1;
        a_code  = 16'h2CD9 ^ 16'h0001;
        @(negedge clk);
        a_code  = 16'h2CD9 ^ 16'h0080;
        @(negedge clk);
        a_valid = 1'b0;
        #1 chk("mid full out_valid", m_ov, 1);
        chk("mid full in_ready", m_ir, 0);
        #2 rst_n = 1'b0;
        #1 chk("mid rst out_valid", m_ov, 0);
        chk("mid rst corr_cnt", m_cc, 0);
        chk("mid rst uncorr_cnt", m_uc, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        a_ready  = 1'b1;
        m_corr   = '{0, 0};
        m_uncorr = '{0, 0};
        #1 chk("post rst in_ready", m_ir, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post rst stale", m_ov, 0);
        end

        latency_beat(16'h2CD9 ^ 16'h0004, 1'b0, "clr pre");
        latency_beat(16'h2CD9 ^ 16'h0020, 1'b1, "clr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
